// File: rtl/awgn_stats.sv
// awgn_stats: windowed count / sum / sum-of-squares / peak-magnitude sink for a signed sample stream.
// Define AWGN_STATS_HIST_EN to add the 32-bin histogram, its CLEAR state and hist_data readback.
module awgn_stats #(
    parameter int W     = 16,
    parameter int CNT_W = 24
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [CNT_W-1:0]          win_len,
    input  logic                      in_valid,
    input  logic [W-1:0]              in_data,
    output logic                      in_ready,
    output logic                      busy,
    output logic                      done,
    output logic signed [CNT_W+W-1:0] sum,
    output logic [CNT_W+2*W-1:0]      sumsq,
    output logic [W-1:0]              max_abs,
    input  logic [4:0]                hist_addr,
    output logic [CNT_W-1:0]          hist_data,
    output logic [1:0]                dbg_state
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CLEAR = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] win_q;
    logic [CNT_W-1:0] acc_cnt;
    logic             start_ok;
    logic             accept;
    logic             run_end;
    logic             s1_valid;
    logic [W-1:0]     s1_data;
    logic [2*W-1:0]   s1_sq;
    logic [W-1:0]     s1_abs;
    logic [2*W-1:0]   din_ext;
    logic [2*W-1:0]   sq_full;
    logic [W-1:0]     din_abs;

    // Handshake: a sample transfers on a rising edge where in_valid && in_ready; in_ready
    // depends only on registered state, never on in_valid, and in_data is held by the source.
    assign start_ok  = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign in_ready  = (state == ST_RUN) && (acc_cnt != win_q);
    assign accept    = in_valid && in_ready;
    assign busy      = (state == ST_CLEAR) || (state == ST_RUN);
    assign dbg_state = state;
    assign run_end   = (acc_cnt == win_q) && !s1_valid;

    // The low 2W bits of the sign-extended product are the exact square (at most 2^(2W-2)).
    assign din_ext = {{W{in_data[W-1]}}, in_data};
    assign sq_full = din_ext * din_ext;

    always_comb begin
        din_abs = in_data;
        if (in_data[W-1]) begin
            if (in_data[W-2:0] == '0)
                din_abs = {1'b0, {(W-1){1'b1}}};
            else
                din_abs = ~in_data + {{(W-1){1'b0}}, 1'b1};
        end
    end

`ifdef AWGN_STATS_HIST_EN
    logic [4:0]       clr_idx;
    logic [4:0]       din_bin;
    logic             h_valid;
    logic [4:0]       h_idx;
    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] h_inc;
    logic [CNT_W-1:0] hist_mem [32];

    // Offset-binary top five bits: bin 0 is most negative, bin 31 most positive.
    assign din_bin = {~in_data[W-1], in_data[W-2:W-5]};
    assign h_inc   = (&h_cnt) ? h_cnt : h_cnt + {{(CNT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clr_idx   <= '0;
            h_valid   <= 1'b0;
            h_idx     <= '0;
            h_cnt     <= '0;
            hist_data <= '0;
        end else begin
            if (start_ok)
                clr_idx <= '0;
            else if (state == ST_CLEAR)
                clr_idx <= clr_idx + 5'd1;
            h_valid <= accept;
            if (accept) begin
                h_idx <= din_bin;
                // The bin being written this edge is stale in the array, so take the new count.
                h_cnt <= (h_valid && (h_idx == din_bin)) ? h_inc : hist_mem[din_bin];
            end
            hist_data <= hist_mem[hist_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (state == ST_CLEAR)
            hist_mem[clr_idx] <= '0;
        else if (h_valid)
            hist_mem[h_idx] <= h_inc;
    end
`else
    logic unused_hist_addr;
    assign unused_hist_addr = ^hist_addr;
    assign hist_data        = '0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
`ifdef AWGN_STATS_HIST_EN
                    state_nxt = ST_CLEAR;
`else
                    state_nxt = ST_RUN;
`endif
                end
            end
            ST_CLEAR: begin
`ifdef AWGN_STATS_HIST_EN
                if (clr_idx == 5'd31)
                    state_nxt = ST_RUN;
`else
                state_nxt = ST_RUN;
`endif
            end
            ST_RUN: begin
                if (run_end)
                    state_nxt = ST_DONE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            done     <= 1'b0;
            win_q    <= '0;
            acc_cnt  <= '0;
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_sq    <= '0;
            s1_abs   <= '0;
            sum      <= '0;
            sumsq    <= '0;
            max_abs  <= '0;
        end else begin
            state    <= state_nxt;
            done     <= (state == ST_RUN) && (state_nxt == ST_DONE);
            s1_valid <= accept;
            if (accept) begin
                s1_data <= in_data;
                s1_sq   <= sq_full;
                s1_abs  <= din_abs;
                acc_cnt <= acc_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (start_ok) begin
                win_q   <= win_len;
                acc_cnt <= '0;
                sum     <= '0;
                sumsq   <= '0;
                max_abs <= '0;
            end else if (s1_valid) begin
                sum   <= sum + {{CNT_W{s1_data[W-1]}}, s1_data};
                sumsq <= sumsq + {{CNT_W{1'b0}}, s1_sq};
                if (s1_abs > max_abs)
                    max_abs <= s1_abs;
            end
        end
    end
endmodule
